// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared sizing constants for the execute-stage divider.
// The FSM state encoding stays local to div_unit; only the default
// operand width is shared here.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder (HI), quotient (LO)}. It stalls the pipeline while
// working and emits a one-cycle valid pulse. It can be flushed by cancel.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous active-high reset
//   start      request, sampled only in IDLE
//   signed_div 1 = DIV (two's complement), 0 = DIVU; captured with start
//   a, b       dividend / divisor; captured with start
//   cancel     flush, aborts any operation and suppresses valid
//   busy       high in BUSY and DONE (stall source)
//   valid      one-cycle pulse, result meaningful only in this cycle
//   result     {remainder, quotient}, registered, held until the next DONE
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cancel,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned       CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;      // partial remainder
    logic [WIDTH-1:0]   quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dsr;      // divisor magnitude
    logic               sign_q;
    logic               sign_r;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               take;

    // Two's-complement negate when requested; the most negative value maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
        return neg ? WIDTH'(-x) : x;
    endfunction

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dsr};
        qbit     = ~trial[WIDTH];
        rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], qbit};
    end

    assign take = start & ~cancel;

    // Next-state logic; cancel overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = (b == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) begin
            state_next = IDLE;
        end
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            valid <= (state_next == DONE);
        end
    end

    // Operand capture, iteration and final sign correction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dsr    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
        end else if (cancel) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r <= signed_div & a[WIDTH-1];
                        quo    <= cond_neg(a, signed_div & a[WIDTH-1]);
                        dsr    <= cond_neg(b, signed_div & b[WIDTH-1]);
                        rem    <= '0;
                        cnt    <= '0;
                        // Divide by zero: raw dividend in HI, all ones in LO.
                        if (b == '0) begin
                            result <= {a, {WIDTH{1'b1}}};
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result <= {cond_neg(rem_next, sign_r),
                                   cond_neg(quo_next, sign_q)};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : div_unit

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected {rem, quo} pairs are
// computed from 64-bit integer arithmetic when a request is driven and
// compared whenever the DUT pulses valid.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cancel;
    logic           busy;
    logic           valid;
    logic [2*W-1:0] result;

    int             errors = 0;
    int             checks = 0;
    logic [63:0]    sb[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .valid      (valid),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: signed ops via sign-extended 64-bit math (truncating division,
    // remainder takes the dividend's sign), then wrap to 32 bits.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sd) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic sd, input logic [31:0] x, input logic [31:0] y);
        start      = 1'b1;
        signed_div = sd;
        a          = x;
        b          = y;
        sb.push_back(model(sd, x, y));
    endtask

    // Counts cycles from the next edge until valid, bounded.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < 80);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic finish_op(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 64'({busy, valid}), 64'd0);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(valid), 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("result", result, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        rst        = 1'b1;
        start      = 1'b0;
        cancel     = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b0, 32'd100, 32'd7);
        wait_valid("divu_100_7", 33);
        check("divu_100_7_const", result, {32'd2, 32'd14});
        finish_op("divu_100_7");

        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_valid("div_m7_2", 33);
        finish_op("div_m7_2");

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid("div_min_m1", 33);
        check("div_min_m1_const", result, {32'd0, 32'h8000_0000});
        finish_op("div_min_m1");

        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid("divu_min_m1", 33);
        finish_op("divu_min_m1");

        issue(1'b0, 32'h0000_1234, 32'd0);
        wait_valid("divu_by0", 1);
        check("divu_by0_const", result, {32'h0000_1234, 32'hFFFF_FFFF});
        finish_op("divu_by0");

        issue(1'b1, 32'hFFFF_FF00, 32'd0);
        wait_valid("div_by0", 1);
        finish_op("div_by0");

        // Cancel sampled at edge T+10, restart at edge T+11.
        issue(1'b0, 32'hFFFF_0000, 32'd3);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        start  = 1'b0;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_valid", 64'(valid), 64'd0);
        cancel = 1'b0;
        issue(1'b0, 32'd9, 32'd3);
        wait_valid("after_cancel", 33);
        finish_op("after_cancel");

        // Start held through valid; second request is taken two edges later.
        issue(1'b0, 32'd50, 32'd5);
        wait_valid("b2b_first", 33);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_valid("b2b_second", 34);
        finish_op("b2b_second");

        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) y = 32'hFFFF_FFFD;
            if (y == 32'd0) y = 32'd1;
            issue(i[0], x, y);
            wait_valid("random", 33);
            finish_op("random");
        end

        // Reset sampled at edge T+5 of an operation.
        issue(1'b1, 32'd1000, 32'hFFFF_FFFD);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_result", result, 64'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_quiet_busy", 64'(busy), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_unit
